beep_scheduler: RTL

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

---
 rtl/beep_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/beep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : beep_scheduler
// Purpose  : Arbitrates three buzzer requesters (short, double, long beep)
//            with fixed priority long > double > short and plays the granted
//            pattern on a square-wave buzzer output. Requests are latched as
//            pending bits, so nothing is lost while a pattern plays, and an
//            active pattern is never preempted or restarted.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            req   - [0] short, [1] double, [2] long; single-cycle pulses
//            grant - one-hot requester currently playing, 0 when none
//            busy  - high whenever a pattern or its trailing gap is active
//            beep  - buzzer drive, idles at 1, toggles while tone is on
// Revision : 1.0 - initial release
// ============================================================================
module beep_scheduler #(
    parameter int TONE_DIV = 25000,
    parameter int UNIT_CYC = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       busy,
    output logic       beep
);

    // Unit counter must reach UNIT_CYC*4-1 (the long pattern's only segment).
    localparam int c_cnt_w  = $clog2(UNIT_CYC * 4);
    localparam int c_tone_w = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [c_cnt_w-1:0]  c_unit_term = c_cnt_w'(UNIT_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_long_term = c_cnt_w'(UNIT_CYC * 4 - 1);
    localparam logic [c_tone_w-1:0] c_tone_term = c_tone_w'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          pend_q,  pend_d;
    logic [2:0]          grant_q, grant_d;
    logic                busy_q,  busy_d;
    logic                beep_q,  beep_d;
    logic [1:0]          seg_q,   seg_d;
    logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
    logic [c_tone_w-1:0] tone_q,  tone_d;

    logic [2:0]          w_pick;
    logic [2:0]          w_clr;
    logic [c_cnt_w-1:0]  w_term;
    logic                w_seg_done;

    // Fixed-priority pick of the pending requester to serve next.
    always_comb begin
        w_pick = 3'b000;
        if (pend_q[2]) begin
            w_pick = 3'b100;
        end else if (pend_q[1]) begin
            w_pick = 3'b010;
        end else if (pend_q[0]) begin
            w_pick = 3'b001;
        end
    end

    // Only the long pattern has a 4-unit segment; every other segment,
    // including the gap (grant is 0 there), lasts one unit.
    assign w_term     = grant_q[2] ? c_long_term : c_unit_term;
    assign w_seg_done = (cnt_q == w_term);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beep_d  = beep_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        w_clr   = 3'b000;

        case (state_q)
            S_IDLE: begin
                grant_d = 3'b000;
                beep_d  = 1'b1;
                if (pend_q != 3'b000) begin
                    state_d = S_ON;
                    grant_d = w_pick;
                    w_clr   = w_pick;
                    seg_d   = 2'd0;
                    cnt_d   = '0;
                    tone_d  = '0;
                    beep_d  = 1'b0;
                end
            end

            S_ON: begin
                if (w_seg_done) begin
                    cnt_d  = '0;
                    tone_d = '0;
                    beep_d = 1'b1;
                    // Only the double pattern has a segment after its first ON.
                    if (grant_q[1] && (seg_q == 2'd0)) begin
                        state_d = S_OFF;
                        seg_d   = 2'd1;
                    end else begin
                        state_d = S_GAP;
                        grant_d = 3'b000;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                    if (tone_q == c_tone_term) begin
                        tone_d = '0;
                        beep_d = ~beep_q;
                    end else begin
                        tone_d = tone_q + c_tone_w'(1);
                    end
                end
            end

            S_OFF: begin
                if (w_seg_done) begin
                    state_d = S_ON;
                    seg_d   = seg_q + 2'd1;
                    cnt_d   = '0;
                    tone_d  = '0;
                    beep_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end

            S_GAP: begin
                if (w_seg_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                beep_d  = 1'b1;
                cnt_d   = '0;
                tone_d  = '0;
                seg_d   = 2'd0;
            end
        endcase

        // A new request on the same edge as its grant-clear wins.
        pend_d = (pend_q & ~w_clr) | req;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 3'b000;
            grant_q <= 3'b000;
            busy_q  <= 1'b0;
            beep_q  <= 1'b1;
            seg_q   <= 2'd0;
            cnt_q   <= '0;
            tone_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            beep_q  <= beep_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign beep  = beep_q;

endmodule
`default_nettype wire
